// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive stimulus and check engine for a small
// combinational gate. It drives every input vector in ascending order, holds
// each one for SETTLE_CYCLES cycles, samples dut_out once and compares it
// against the EXP_TT truth table. At the end of a sweep it reports
// pass/fail, the mismatch count and the first failing vector.
//
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN
//   defined   - the first mismatch ends the sweep immediately
//   undefined - the full sweep always runs and every mismatch is counted
`timescale 1ns/1ps

module gate_sweep_checker #(
    parameter int                        N_IN          = 2,
    parameter int                        SETTLE_CYCLES = 2,
    parameter logic [(2**N_IN)-1:0]      EXP_TT        = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dut_out,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Settle counter reaches this value on the last cycle of the window.
    localparam logic [7:0]      CNT_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    state_t      state;
    logic [7:0]  settle_cnt;
    logic        mismatch;

    // Gate output disagrees with the truth-table entry for the current vector.
    assign mismatch = (dut_out != EXP_TT[stim]);

    // Sweep sequencer: state, stimulus, settle timing and result registers.
    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; mixing in = would make order of statements
    // matter and break the err_count/first_fail relationship below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        stim       <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        // Old err_count is still zero only on the first miss.
                        if (err_count == '0) begin
                            first_fail <= stim;
                        end
                    end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (stim == VEC_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        stim       <= stim + N_IN'(1);
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
`else
                    if (stim == VEC_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        // A miss on the final vector is not yet in err_count.
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        stim       <= stim + N_IN'(1);
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
`endif
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: scoreboard bench for gate_sweep_checker with default
// parameters (2-input AND truth table). Stimulus threads push the expected
// sweep result; a monitor pops and compares whenever done pulses.
`timescale 1ns/1ps

module tb_gate_sweep_checker;

    localparam int N_IN = 2;

    typedef struct {
        int exp_cyc;
        int err;
        int ff;
        int pass;
        int stim;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            dut_out;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;

    int   mode = 0;   // 0: correct AND, 1: stuck at 0, 2: stuck at 1
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t e;

    gate_sweep_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dut_out    (dut_out),
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gate model driven by the checker's stimulus.
    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0:       dut_out = stim[1] & stim[0];
            1:       dut_out = 1'b0;
            default: dut_out = 1'b1;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.exp_cyc);
                check("err_count", int'(err_count), e.err);
                check("first_fail", int'(first_fail), e.ff);
                check("pass", int'(pass), e.pass);
                check("stim_at_done", int'(stim), e.stim);
            end
        end
    end

    task automatic push(input int exp_cyc, input int err, input int ff,
                        input int p, input int s);
        exp_t x;
        x.exp_cyc = exp_cyc;
        x.err     = err;
        x.ff      = ff;
        x.pass    = p;
        x.stim    = s;
        sb.push_back(x);
    endtask

    // Pulse start for one edge; t0 is the index of the accepting edge.
    task automatic launch(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for all pending expectations, bounded, then watch a few idle cycles.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int t0;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stim", int'(stim), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_ff", int'(first_fail), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct AND gate: stim 0,1,2,3 each held 3 cycles, done at +12
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        push(t0 + 12, 0, 0, 1, 3);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("stim_seq", int'(stim), (k < 12) ? k / 3 : 3);
            check("busy_seq", int'(busy), (k <= 12) ? 1 : 0);
        end
        drain();

        // Stuck at 0: only vector 3 mismatches
        mode = 1;
        launch(t0);
        push(t0 + 12, 1, 3, 0, 3);
        drain();

        // Stuck at 1: vectors 0,1,2 mismatch
        mode = 2;
        launch(t0);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        push(t0 + 3, 1, 0, 0, 0);
`else
        push(t0 + 12, 3, 0, 0, 3);
`endif
        drain();

        // start re-pulsed while busy at stim=1 is ignored
        mode = 0;
        launch(t0);
        push(t0 + 12, 0, 0, 1, 3);
        while (cyc < t0 + 4) @(negedge clk);
        check("repulse_stim", int'(stim), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held high relaunches right after DONE
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        push(t0 + 12, 0, 0, 1, 3);
        push(t0 + 26, 0, 0, 1, 3);
        n = 0;
        while (cyc < t0 + 14 && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("relaunch_busy", int'(busy), 1);
        drain();

        // Reset mid-SETTLE of vector 2 discards the sweep
        mode = 2;
        launch(t0);
        repeat (7) @(negedge clk);
        check("pre_rst_stim", int'(stim), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_stim", int'(stim), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_err", int'(err_count), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        repeat (20) @(negedge clk);
        launch(t0);
        push(t0 + 12, 0, 0, 1, 3);
        drain();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Self-checking stimulus engine that sits directly upstream of a small combinational gate (e.g. and_gate). It walks the gate's inputs through every combination and samples the gate output after a settle window. It compares each sample against a parameterised truth table and reports pass/fail, an error count and the first failing vector. It replaces hand-written per-gate vector lists in gate benches and also runs in hardware as a built-in self-test (BIST) sweep.

Parameters:
N_IN, 2, number of gate inputs driven; legal range 1..6.
SETTLE_CYCLES, 2, cycles that each vector is held before sampling; legal range 1..255.
EXP_TT, 4'b1000, expected truth table, 2**N_IN bits; bit i is the expected output for input vector i (default = 2-input AND).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  sweep request; sampled only in IDLE.
dut_out  input  1  output of the gate under test.
stim  output  N_IN  registered input vector driven to the gate; stim[0] = LSB input (b for a 2-input gate, stim[1] = a).
busy  output  1  high from the cycle after start is accepted until DONE is left.
done  output  1  single-cycle pulse when the sweep completes.
pass  output  1  valid when done is high; held until the next accepted start; 1 = zero mismatches.
err_count  output  N_IN+1  number of mismatching vectors in the last sweep; cannot overflow.
first_fail  output  N_IN  vector index of the first mismatch; 0 when err_count = 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge moves to SETTLE.
  - The same edge clears stim, err_count, first_fail, pass and the settle counter, and sets busy=1.
- SETTLE:
  - stim is held and the counter increments each cycle.
  - After exactly SETTLE_CYCLES cycles in SETTLE, moves to SAMPLE.
- SAMPLE (1 cycle):
  - Compares dut_out against EXP_TT[stim].
  - On mismatch, err_count increments; if err_count was 0, first_fail<=stim.
  - If stim == 2**N_IN-1, moves to DONE; otherwise stim<=stim+1, counter cleared, returns to SETTLE.
- DONE (1 cycle):
  - done=1; pass=1 iff final err_count==0 (includes a mismatch on the last vector); busy=0 on exit.
  - Next state is IDLE.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles. With the start edge at t0, done is high in the cycle after edge t0 + 2**N_IN*(SETTLE_CYCLES+1). Defaults give done 12 cycles after the start edge.
- stim does not wrap: it stays at the final vector through DONE and returns to 0 only on the next start or on reset.
- start while busy (SETTLE/SAMPLE/DONE): ignored, no queueing; start held high continuously re-launches from IDLE each sweep.
- dut_out is sampled raw (no synchroniser); the gate is assumed on the same clock domain, with combinational settle covered by SETTLE_CYCLES.
- Reset mid-sweep: all outputs return to reset values immediately; no done pulse; the partial sweep is discarded.

Optional Feature:
GATE_CHK_STOP_ON_FAIL_EN
- Defined: the first mismatch in SAMPLE moves directly to DONE.
  - err_count=1, first_fail=failing vector, pass=0; stim holds the failing vector.
  - done latency shortens accordingly.
- Undefined: the full sweep always runs, and err_count counts every mismatching vector.

Test Plan:
- Correct AND model on dut_out, defaults, start pulse: done exactly 12 cycles after start edge; pass=1, err_count=0, first_fail=0; stim sequence 0,1,2,3, each held 3 cycles.
- dut_out stuck at 0: pass=0, err_count=1, first_fail=3.
- dut_out stuck at 1: pass=0, err_count=3, first_fail=0.
- start re-pulsed while stim=1: ignored, a single done pulse at cycle 12, results unchanged; start held high re-launches a new sweep right after DONE.
- rst_n driven low mid-SETTLE of vector 2: stim=0, busy=0, err_count=0 immediately, no done; a new start then gives a clean 12-cycle sweep with pass=1.
- With GATE_CHK_STOP_ON_FAIL_EN and dut_out stuck at 1: done 3 cycles after start edge (first SAMPLE mismatches at vector 0), err_count=1, first_fail=0, stim=0, pass=0.
